// File: rtl/ahb2apb_multi.sv
// rtl/ahb2apb_multi.sv - AHB-Lite to multi-slave APB3/APB4 bridge with slave decode, posted writes and PREADY timeout
module ahb2apb_multi #(
    parameter int ADDRWIDTH = 16,
    parameter int NUM_SLV   = 4,
    parameter int SLV_LSB   = 12,
    parameter bit POSTED_WR = 1'b1,
    parameter int TIMEOUT   = 255
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     PCLKEN,
    input  logic                     HSEL,
    input  logic [ADDRWIDTH-1:0]     HADDR,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic [3:0]               HPROT,
    input  logic                     HWRITE,
    input  logic                     HREADY,
    input  logic [31:0]              HWDATA,
    output logic                     HREADYOUT,
    output logic [31:0]              HRDATA,
    output logic                     HRESP,
    output logic [ADDRWIDTH-1:0]     PADDR,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [3:0]               PSTRB,
    output logic [2:0]               PPROT,
    output logic [31:0]              PWDATA,
    output logic [NUM_SLV-1:0]       PSEL,
    input  logic [32*NUM_SLV-1:0]    PRDATA,
    input  logic [NUM_SLV-1:0]       PREADY,
    input  logic [NUM_SLV-1:0]       PSLVERR,
    output logic                     WERR,
    input  logic                     WERR_CLR,
    output logic                     APBACTIVE
);
    localparam int SLVW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2} state_t;
    state_t state;

    logic                    pend, h_write;
    logic [ADDRWIDTH-1:2]    h_addr;
    logic [SLVW-1:0]         h_idx, p_idx;
    logic [3:0]              h_strb, a_strb;
    logic [2:0]              h_prot;
    logic                    p_posted;
    logic [15:0]             to_cnt;
    logic [31:0]             sel_rdata;
    logic                    sel_ready, sel_err;
    logic                    acc, launch, launch_posted, h_ok, timeout;
    logic                    unused_ok;

    assign unused_ok = &{1'b0, HTRANS[0], HPROT[3:2]};

    assign acc           = HSEL && HTRANS[1] && HREADY;
    assign h_ok          = int'(h_idx) < NUM_SLV;
    assign launch        = (state == S_IDLE) && pend;
    assign launch_posted = launch && POSTED_WR && h_write && h_ok;
    assign timeout       = (TIMEOUT != 0) && (to_cnt == 16'(TIMEOUT));

    always_comb begin
        a_strb = 4'h0;
        if (HWRITE) begin
            case (HSIZE)
                3'b000:  a_strb = 4'b0001 << HADDR[1:0];
                3'b001:  a_strb = HADDR[1] ? 4'hC : 4'h3;
                default: a_strb = 4'hF;
            endcase
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        PSEL      = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (int'(p_idx) == i) begin
                sel_rdata = PRDATA[32*i +: 32];
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                PSEL[i]   = (state == S_SETUP) || (state == S_ACCESS);
            end
        end
    end

    // Once the launch has emptied the hold register, AHB may run ahead of the APB engine
    always_comb begin
        case (state)
            S_IDLE:         HREADYOUT = !pend || launch_posted;
            S_DONE, S_ERR2: HREADYOUT = 1'b1;
            S_ERR1:         HREADYOUT = 1'b0;
            default:        HREADYOUT = !pend;
        endcase
    end

    assign PENABLE   = (state == S_ACCESS);
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
    assign APBACTIVE = (HSEL && HTRANS[1]) || pend || (state != S_IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            pend     <= 1'b0;
            h_write  <= 1'b0;
            h_addr   <= '0;
            h_idx    <= '0;
            h_strb   <= '0;
            h_prot   <= '0;
            p_idx    <= '0;
            p_posted <= 1'b0;
            to_cnt   <= '0;
            HRDATA   <= '0;
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PSTRB    <= '0;
            PPROT    <= '0;
            PWDATA   <= '0;
            WERR     <= 1'b0;
        end else begin
            if (acc) begin
                pend    <= 1'b1;
                h_write <= HWRITE;
                h_addr  <= HADDR[ADDRWIDTH-1:2];
                h_idx   <= HADDR[SLV_LSB +: SLVW];
                h_strb  <= a_strb;
                h_prot  <= {~HPROT[0], 1'b0, HPROT[1]};
            end else if (launch) begin
                pend <= 1'b0;
            end

            if (WERR_CLR) WERR <= 1'b0;

            case (state)
                S_IDLE: if (pend) begin
                    PADDR    <= {h_addr, 2'b00};
                    PWRITE   <= h_write;
                    PSTRB    <= h_strb;
                    PPROT    <= h_prot;
                    PWDATA   <= HWDATA;
                    p_idx    <= h_idx;
                    p_posted <= POSTED_WR && h_write;
                    if (!h_ok)       state <= S_ERR1;
                    else if (PCLKEN) state <= S_SETUP;
                    else             state <= S_WAIT;
                end
                S_WAIT:  if (PCLKEN) state <= S_SETUP;
                S_SETUP: if (PCLKEN) begin
                    state  <= S_ACCESS;
                    to_cnt <= '0;
                end
                S_ACCESS: if (PCLKEN) begin
                    if (sel_ready && !sel_err) begin
                        if (p_posted) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DONE;
                            if (!PWRITE) HRDATA <= sel_rdata;
                        end
                    end else if (sel_ready || timeout) begin
                        if (p_posted) begin
                            state <= S_IDLE;
                            WERR  <= 1'b1;
                        end else begin
                            state <= S_ERR1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_ERR1:  state <= S_ERR2;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb2apb_multi.sv
// tb/tb_ahb2apb_multi.sv - directed bench for ahb2apb_multi (posted/3-slave/timeout-4 and non-posted instances)
module tb_ahb2apb_multi;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        PCLKEN = 1'b1;
    logic        hsel_a = 1'b0, hsel_b = 1'b0;
    logic [15:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0;
    logic [3:0]  hprot = '0;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = '0;
    logic        werr_clr = 1'b0;

    logic        hreadyout_a, hresp_a, pwrite_a, penable_a, werr_a, apbactive_a;
    logic [31:0] hrdata_a, pwdata_a;
    logic [15:0] paddr_a;
    logic [3:0]  pstrb_a;
    logic [2:0]  pprot_a, psel_a;
    logic [95:0] prdata_a = {32'hCAFE0001, 32'h22220001, 32'h11110000};
    logic [2:0]  pready_a = 3'b111, pslverr_a = 3'b000;

    logic        hreadyout_b, hresp_b, pwrite_b, penable_b, werr_b, apbactive_b;
    logic [31:0] hrdata_b, pwdata_b;
    logic [15:0] paddr_b;
    logic [3:0]  pstrb_b, psel_b;
    logic [2:0]  pprot_b;
    logic [127:0] prdata_b = '0;
    logic [3:0]  pready_b = 4'b1111, pslverr_b = 4'b0000;

    int total = 0;
    int bad = 0;

    always #5 HCLK = ~HCLK;

    ahb2apb_multi #(.ADDRWIDTH(16), .NUM_SLV(3), .SLV_LSB(12), .POSTED_WR(1'b1), .TIMEOUT(4)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .HSEL(hsel_a), .HADDR(haddr),
        .HTRANS(htrans), .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HREADY(hreadyout_a),
        .HWDATA(hwdata), .HREADYOUT(hreadyout_a), .HRDATA(hrdata_a), .HRESP(hresp_a),
        .PADDR(paddr_a), .PWRITE(pwrite_a), .PENABLE(penable_a), .PSTRB(pstrb_a), .PPROT(pprot_a),
        .PWDATA(pwdata_a), .PSEL(psel_a), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
        .WERR(werr_a), .WERR_CLR(werr_clr), .APBACTIVE(apbactive_a)
    );

    ahb2apb_multi #(.ADDRWIDTH(16), .NUM_SLV(4), .SLV_LSB(12), .POSTED_WR(1'b0), .TIMEOUT(255)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .HSEL(hsel_b), .HADDR(haddr),
        .HTRANS(htrans), .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HREADY(hreadyout_b),
        .HWDATA(hwdata), .HREADYOUT(hreadyout_b), .HRDATA(hrdata_b), .HRESP(hresp_b),
        .PADDR(paddr_b), .PWRITE(pwrite_b), .PENABLE(penable_b), .PSTRB(pstrb_b), .PPROT(pprot_b),
        .PWDATA(pwdata_b), .PSEL(psel_b), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
        .WERR(werr_b), .WERR_CLR(werr_clr), .APBACTIVE(apbactive_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic addr_phase(input logic to_a, input logic [15:0] ad, input logic wr, input logic [2:0] sz);
        hsel_a = to_a;
        hsel_b = !to_a;
        haddr  = ad;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
    endtask

    task automatic idle_bus();
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        step();
        step();
        chk("rst_hready", hreadyout_a, 1);
        chk("rst_psel", psel_a, 0);
        chk("rst_penable", penable_a, 0);
        chk("rst_hresp", hresp_a, 0);
        chk("rst_werr", werr_a, 0);
        chk("rst_active", apbactive_a, 0);
        chk("rst_hrdata", hrdata_a, 0);
        HRESETn = 1'b1;
        step();

        // read from slave 2, zero-wait
        hprot = 4'b0011;
        addr_phase(1'b1, 16'h2004, 1'b0, 3'b010);
        step();
        chk("rd_t1_hready", hreadyout_a, 0);
        idle_bus();
        step();
        chk("rd_t2_psel", psel_a, 3'b100);
        chk("rd_t2_paddr", paddr_a, 16'h2004);
        chk("rd_t2_penable", penable_a, 0);
        chk("rd_t2_pprot", pprot_a, 3'b001);
        chk("rd_t2_pstrb", pstrb_a, 0);
        chk("rd_t2_active", apbactive_a, 1);
        step();
        chk("rd_t3_penable", penable_a, 1);
        step();
        chk("rd_t4_hready", hreadyout_a, 1);
        chk("rd_t4_hrdata", hrdata_a, 32'hCAFE0001);
        chk("rd_t4_hresp", hresp_a, 0);
        step();

        // back-to-back posted byte writes
        hprot = 4'b0000;
        addr_phase(1'b1, 16'h1001, 1'b1, 3'b000);
        step();
        chk("wr1_t1_hready", hreadyout_a, 1);
        hwdata = 32'h1111A511;
        addr_phase(1'b1, 16'h1003, 1'b1, 3'b000);
        step();
        chk("wr1_t2_hready", hreadyout_a, 0);
        chk("wr1_psel", psel_a, 3'b010);
        chk("wr1_pstrb", pstrb_a, 4'b0010);
        chk("wr1_pwdata", pwdata_a, 32'h1111A511);
        chk("wr1_paddr", paddr_a, 16'h1000);
        chk("wr1_pwrite", pwrite_a, 1);
        chk("wr1_pprot", pprot_a, 3'b100);
        idle_bus();
        hwdata = 32'h77333333;
        step();
        chk("wr2_t3_hready", hreadyout_a, 0);
        step();
        chk("wr2_t4_hready", hreadyout_a, 1);
        step();
        chk("wr2_pstrb", pstrb_a, 4'b1000);
        chk("wr2_pwdata", pwdata_a, 32'h77333333);
        chk("wr2_psel", psel_a, 3'b010);
        step();
        step();
        step();

        // posted write with PSLVERR -> sticky WERR
        pslverr_a = 3'b010;
        addr_phase(1'b1, 16'h1000, 1'b1, 3'b010);
        step();
        chk("pwe_t1_hready", hreadyout_a, 1);
        hwdata = 32'hDEADBEEF;
        idle_bus();
        step();
        step();
        step();
        chk("pwe_werr", werr_a, 1);
        chk("pwe_hresp", hresp_a, 0);
        werr_clr = 1'b1;
        step();
        chk("pwe_werr_clr", werr_a, 0);
        werr_clr = 1'b0;
        pslverr_a = 3'b000;
        step();

        // non-posted write with PSLVERR -> two-cycle ERROR
        pslverr_b = 4'b0010;
        addr_phase(1'b0, 16'h1000, 1'b1, 3'b010);
        step();
        chk("npe_t1_hready", hreadyout_b, 0);
        hwdata = 32'h01020304;
        idle_bus();
        step();
        step();
        step();
        chk("npe_err1_hready", hreadyout_b, 0);
        chk("npe_err1_hresp", hresp_b, 1);
        step();
        chk("npe_err2_hready", hreadyout_b, 1);
        chk("npe_err2_hresp", hresp_b, 1);
        step();
        chk("npe_after_hresp", hresp_b, 0);
        chk("npe_werr", werr_b, 0);
        pslverr_b = 4'b0000;
        step();

        // decode error: index 3 with 3 slaves, write is not posted
        addr_phase(1'b1, 16'h3000, 1'b1, 3'b010);
        step();
        chk("dec_t1_hready", hreadyout_a, 0);
        chk("dec_t1_psel", psel_a, 0);
        idle_bus();
        step();
        chk("dec_err1_hresp", hresp_a, 1);
        chk("dec_err1_hready", hreadyout_a, 0);
        chk("dec_err1_psel", psel_a, 0);
        step();
        chk("dec_err2_hresp", hresp_a, 1);
        chk("dec_err2_hready", hreadyout_a, 1);
        step();
        chk("dec_after_hresp", hresp_a, 0);
        chk("dec_werr", werr_a, 0);
        step();

        // PREADY stuck low on slave 0, PCLKEN every 2nd cycle
        pready_a = 3'b110;
        PCLKEN = 1'b1;
        addr_phase(1'b1, 16'h0004, 1'b0, 3'b010);
        for (int t = 1; t <= 16; t++) begin
            step();
            if (t == 1) idle_bus();
            PCLKEN = (t % 2 == 0);
            if (t == 2)  chk("to_wait_psel", psel_a, 0);
            if (t == 4)  chk("to_setup_psel", psel_a, 3'b001);
            if (t == 13) chk("to_t13_hresp", hresp_a, 0);
            if (t == 14) chk("to_t14_penable", penable_a, 1);
            if (t == 15) begin
                chk("to_err1_hresp", hresp_a, 1);
                chk("to_err1_hready", hreadyout_a, 0);
                chk("to_err1_psel", psel_a, 0);
                chk("to_err1_penable", penable_a, 0);
            end
            if (t == 16) begin
                chk("to_err2_hready", hreadyout_a, 1);
                chk("to_hrdata_held", hrdata_a, 32'hCAFE0001);
            end
        end
        PCLKEN = 1'b1;
        pready_a = 3'b111;
        step();

        // reset asserted mid-ACCESS
        pslverr_a = 3'b010;
        addr_phase(1'b1, 16'h1000, 1'b1, 3'b010);
        step();
        chk("rs_t1_hready", hreadyout_a, 1);
        hwdata = 32'h0000FFFF;
        addr_phase(1'b1, 16'h2008, 1'b0, 3'b010);
        step();
        chk("rs_t2_hready", hreadyout_a, 0);
        idle_bus();
        step();
        step();
        chk("rs_werr_set", werr_a, 1);
        pslverr_a = 3'b000;
        step();
        step();
        chk("rs_access_penable", penable_a, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("rs_psel", psel_a, 0);
        chk("rs_penable", penable_a, 0);
        chk("rs_werr", werr_a, 0);
        chk("rs_hready", hreadyout_a, 1);
        chk("rs_active", apbactive_a, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        step();
        prdata_a[95:64] = 32'h5A5A0F0F;
        addr_phase(1'b1, 16'h2000, 1'b0, 3'b010);
        step();
        chk("rs_rd_t1_hready", hreadyout_a, 0);
        idle_bus();
        step();
        chk("rs_rd_psel", psel_a, 3'b100);
        step();
        step();
        chk("rs_rd_hready", hreadyout_a, 1);
        chk("rs_rd_hrdata", hrdata_a, 32'h5A5A0F0F);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb2apb_multi.md
# ahb2apb_multi

AHB-Lite to APB3/APB4 bridge for a bank of up to 16 APB slaves, with integrated slave decode, optional posted writes and a PREADY timeout. It sits between the AHB interconnect and the peripheral cluster, replacing a single-slave bridge plus an external APB mux. All APB-side timing is qualified by PCLKEN, so APB can run at an integer divide of HCLK.

## Interface
- ADDRWIDTH, 16: AHB/APB address width.
- NUM_SLV, 4: number of APB slaves (1..16). SLVW = max(1, clog2(NUM_SLV)).
- SLV_LSB, 12: slave index = HADDR[SLV_LSB +: SLVW].
- POSTED_WR, 1: 1 = writes complete on AHB at launch; 0 = writes wait for APB completion.
- TIMEOUT, 255: max PCLKEN-qualified wait cycles in ACCESS (1..65535); 0 disables.
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- PCLKEN  in  1  APB clock enable.
- HSEL, HADDR[ADDRWIDTH], HTRANS[2], HSIZE[3], HPROT[4], HWRITE, HREADY, HWDATA[32]  in: AHB-Lite slave inputs.
- HREADYOUT  out  1; HRDATA  out  32; HRESP  out  1: AHB response.
- PADDR  out  ADDRWIDTH: word-aligned, [1:0]=0; PWRITE  out  1; PENABLE  out  1; PSTRB  out  4; PPROT  out  3; PWDATA  out  32.
- PSEL  out  NUM_SLV: one-hot select.
- PRDATA  in  32*NUM_SLV: slave i on [32i+31:32i]; PREADY, PSLVERR  in  NUM_SLV.
- WERR  out  1: sticky posted-write error. WERR_CLR  in  1: clears WERR.
- APBACTIVE  out  1: (HSEL & HTRANS[1]) | data phase pending | engine not IDLE.

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY. Hold registers capture address, HWRITE, slave index, PSTRB, PPROT, and a pending flag.
- PSTRB: zero for reads. For writes: word = 4'hF; halfword = 4'h3 or 4'hC by HADDR[1]; byte = one-hot by HADDR[1:0].
- PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
- Engine states: IDLE, WAIT, SETUP, ACCESS, DONE, ERR1, ERR2.
- Launch happens in IDLE with pending=1:
  - APB registers load from the hold registers; PWDATA <= HWDATA; pending clears.
  - Next state is SETUP if PCLKEN, otherwise WAIT.
  - Decode error (index >= NUM_SLV): no PSEL, next state ERR1. Applies to writes too; these are never posted.
- WAIT -> SETUP on PCLKEN.
- SETUP -> ACCESS on PCLKEN.
- ACCESS, evaluated only when PCLKEN:
  - PREADY & ~PSLVERR: read or non-posted write -> DONE (HRDATA <= PRDATA on reads); posted write -> IDLE.
  - PREADY & PSLVERR, or timeout: non-posted -> ERR1; posted -> IDLE and set WERR.
  - Otherwise stay in ACCESS.
- DONE and ERR2 -> IDLE.
- PREADY, PSLVERR and PRDATA are muxed from the selected slave.
- Timeout counter (16 bits):
  - Clears on entry to ACCESS.
  - Increments on PCLKEN & ~PREADY.
  - Timeout fires when the count equals TIMEOUT, evaluated on PCLKEN.
- HREADYOUT:
  - 1 in IDLE with no pending.
  - In the launch cycle: 1 for a posted write, else 0.
  - 0 while pending and not launched.
  - 1 in DONE and ERR2; 0 in ERR1.
  - With pending=0, HREADYOUT = 1 in WAIT, SETUP and ACCESS. This lets AHB run ahead of a posted write.
- HRESP = 1 in ERR1 and ERR2 only.
- HRDATA holds its last read value; it is not updated on error.
- PSEL[idx] = 1 in SETUP and ACCESS; PENABLE = 1 in ACCESS.
- WERR: set has priority over a simultaneous WERR_CLR.

## Timing
- Reset values: HREADYOUT=1; all other outputs 0; engine IDLE; pending=0.
- Reset asserted mid-transfer aborts immediately: PSEL and PENABLE drop asynchronously.
- Read, PCLKEN=1, zero-wait slave:
  - T0 address phase; T1 launch (HREADYOUT=0); T2 SETUP; T3 ACCESS.
  - T4 DONE: HREADYOUT=1, HRDATA valid. Data phase is 4 cycles.
- Posted write: T0 address phase; T1 launch, HREADYOUT=1; T2 SETUP; T3 ACCESS.
- Back-to-back posted write with its address phase at T1:
  - Its data phase waits (HREADYOUT=0) through T2 and T3.
  - Launch at T4 (IDLE); SETUP at T5.
- Each wait state adds one PCLKEN-qualified cycle. With PCLKEN every Nth cycle, SETUP and ACCESS each last N HCLK cycles.
- Engine never stalls on HREADY; HTRANS IDLE/BUSY is ignored.

## Test plan
- Read from slave 2 (HADDR=0x2004, PRDATA2=0xCAFE0001, zero wait, PCLKEN=1) -> PSEL=4'b0100 at T2, PADDR=0x2004, HREADYOUT=1 with HRDATA=0xCAFE0001 at T4, HRESP=0.
- Two posted byte writes, to 0x1001 then 0x1003 -> PSTRB=4'b0010 then 4'b1000; second HREADYOUT=1 exactly at T4; PWDATA matches HWDATA.
- Write to slave 1 with PSLVERR=1, for POSTED_WR=1 and for POSTED_WR=0:
  - POSTED_WR=1: WERR=1 and HRESP stays 0; WERR_CLR pulse clears it.
  - POSTED_WR=0: two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 both cycles).
- NUM_SLV=3, access to index 3 -> no PSEL, ERROR response; a write there is not posted.
- TIMEOUT=4, PREADY stuck low, PCLKEN every 2nd cycle -> error after 4 qualified ACCESS cycles; PSEL=0 on the cycle after.
- HRESETn asserted in ACCESS -> PSEL, PENABLE, WERR and pending all 0 immediately; HREADYOUT=1; the next read proceeds normally.
